// File: rtl/count_decoder.sv
// count_decoder: multi-mode counter code monitor (binary/gray/ring/johnson).
// Build option: COUNT_DECODER_STRICT_STEP_EN makes a hold a bad step.
module count_decoder #(
    parameter int COUNT_WIDTH = 4,
    parameter int LOCK_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   sync_,
    input  logic                   sample_valid_,
    input  logic [1:0]             count_type,
    input  logic                   count_dir,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic [COUNT_WIDTH-1:0] bin_val,
    output logic                   bin_valid,
    output logic                   locked,
    output logic                   code_err,
    output logic                   step_err,
    output logic [7:0]             err_cnt
);

    localparam int W = COUNT_WIDTH;

    // Code types as carried on count_type.
    localparam logic [1:0] T_BIN  = 2'd0;
    localparam logic [1:0] T_GRAY = 2'd1;
    localparam logic [1:0] T_RING = 2'd2;
    localparam logic [1:0] T_JOHN = 2'd3;

    // Moduli are held one bit wider than the code so 2^W fits.
    localparam logic [W:0]   MOD_BIN  = {1'b1, {W{1'b0}}};
    localparam logic [W:0]   MOD_RING = (W + 1)'(W);
    localparam logic [W:0]   MOD_JOHN = (W + 1)'(2 * W);
    localparam logic [W-1:0] ONES     = '1;
    localparam logic [W-1:0] WM1      = W'(W - 1);
    localparam logic [3:0]   THRESH   = 4'(LOCK_THRESH);

`ifdef COUNT_DECODER_STRICT_STEP_EN
    // A stalled counter is treated as a fault.
    localparam bit HOLD_IS_BAD = 1'b1;
`else
    // A stalled counter is allowed (it may simply be disabled).
    localparam bit HOLD_IS_BAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   ref_idx;
    logic [1:0]     ref_type;
    logic [3:0]     good_cnt;

    logic [W-1:0]   pop;
    logic [W-1:0]   gray_bin;
    logic [W-1:0]   ring_idx;
    logic [W-1:0]   john_hi;
    logic [W-1:0]   john_lo;
    logic [W:0]     john_idx;

    logic           code_legal;
    logic [W:0]     idx_x;
    logic [W:0]     mod_m;
    logic [W:0]     diff_raw;
    logic [W:0]     diff;
    logic           is_hold;
    logic           step_ok;
    logic           type_chg;
    logic           do_resync;
    logic           in_acq;
    logic           in_lock;
    logic [3:0]     good_inc;
    logic [7:0]     err_inc;

    // Population count of the incoming code (ring/johnson legality and index).
    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + {{(W-1){1'b0}}, count_in[i]};
        end
    end

    // Gray to binary: each bit is the XOR of itself and all bits above it.
    always_comb begin
        gray_bin = '0;
        for (int i = 0; i < W; i++) begin
            gray_bin[i] = ^(count_in >> i);
        end
    end

    // Ring index: the set bit at position p maps to W-1-p.
    always_comb begin
        ring_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (count_in[i]) begin
                ring_idx = WM1 - W'(i);
            end
        end
    end

    // Johnson: legal shapes are ones packed against the MSB or the LSB.
    always_comb begin
        john_hi = ~(ONES >> pop);
        john_lo = ~(ONES << pop);
        if (count_in[W-1]) begin
            john_idx = {1'b0, pop};
        end else if (pop == '0) begin
            john_idx = '0;
        end else begin
            john_idx = MOD_JOHN - {1'b0, pop};
        end
    end

    // Select legality, index and modulus for the sampled code type.
    always_comb begin
        code_legal = 1'b1;
        idx_x      = {1'b0, count_in};
        mod_m      = MOD_BIN;
        unique case (count_type)
            T_BIN: begin
                idx_x = {1'b0, count_in};
                mod_m = MOD_BIN;
            end
            T_GRAY: begin
                idx_x = {1'b0, gray_bin};
                mod_m = MOD_BIN;
            end
            T_RING: begin
                code_legal = (pop == W'(1));
                idx_x      = {1'b0, ring_idx};
                mod_m      = MOD_RING;
            end
            T_JOHN: begin
                code_legal = (count_in == john_hi) ||
                             (count_in == john_lo);
                idx_x      = john_idx;
                mod_m      = MOD_JOHN;
            end
            default: begin
                code_legal = 1'b1;
            end
        endcase
    end

    // Step distance (idx - ref) mod M and its classification.
    always_comb begin
        diff_raw = idx_x + mod_m - {1'b0, ref_idx};
        if (diff_raw >= mod_m) begin
            diff = diff_raw - mod_m;
        end else begin
            diff = diff_raw;
        end
        is_hold = (diff == '0);
        // With M==2 a step of 1 is both up and down, so either dir passes.
        step_ok = is_hold ||
                  ((diff == (W + 1)'(1)) && count_dir) ||
                  ((diff == mod_m - (W + 1)'(1)) && !count_dir);
    end

    // Branch selection for the lock FSM on a legal sample.
    always_comb begin
        type_chg  = (count_type != ref_type);
        do_resync = (state == ST_UNLOCKED) || type_chg;
        in_acq    = (state == ST_ACQUIRE) && !type_chg;
        in_lock   = (state == ST_LOCKED) && !type_chg;
        good_inc  = good_cnt + 4'd1;
        err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end

    // Lock FSM with registered decode outputs, pulses and error counter.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= ST_UNLOCKED;
            ref_idx   <= '0;
            ref_type  <= T_BIN;
            good_cnt  <= '0;
            bin_val   <= '0;
            bin_valid <= 1'b0;
            locked    <= 1'b0;
            code_err  <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            bin_valid <= 1'b0;
            code_err  <= 1'b0;
            step_err  <= 1'b0;
            if (!sync_) begin
                state    <= ST_UNLOCKED;
                good_cnt <= '0;
                locked   <= 1'b0;
                err_cnt  <= '0;
            end else if (!sample_valid_) begin
                if (!code_legal) begin
                    state    <= ST_UNLOCKED;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                    code_err <= 1'b1;
                    err_cnt  <= err_inc;
                end else begin
                    bin_valid <= 1'b1;
                    bin_val   <= idx_x[W-1:0];
                    ref_idx   <= idx_x[W-1:0];
                    ref_type  <= count_type;
                    unique case (1'b1)
                        do_resync: begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                        in_acq: begin
                            if (is_hold) begin
                                if (HOLD_IS_BAD) begin
                                    good_cnt <= '0;
                                end
                            end else if (step_ok) begin
                                good_cnt <= good_inc;
                                if (good_inc >= THRESH) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                        in_lock: begin
                            if (!step_ok || (HOLD_IS_BAD && is_hold)) begin
                                state    <= ST_ACQUIRE;
                                good_cnt <= '0;
                                locked   <= 1'b0;
                                step_err <= 1'b1;
                                err_cnt  <= err_inc;
                            end
                        end
                        default: begin
                            state    <= ST_UNLOCKED;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_count_decoder.sv
// tb_count_decoder: directed + randomized check of count_decoder
// against a table-driven behavioural model.
module tb_count_decoder;

    localparam int W   = 4;
    localparam int THR = 2;

`ifdef COUNT_DECODER_STRICT_STEP_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_;
    logic         sync_;
    logic         sample_valid_;
    logic [1:0]   count_type;
    logic         count_dir;
    logic [W-1:0] count_in;
    logic [W-1:0] bin_val;
    logic         bin_valid;
    logic         locked;
    logic         code_err;
    logic         step_err;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    count_decoder #(
        .COUNT_WIDTH(W),
        .LOCK_THRESH(THR)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .sync_        (sync_),
        .sample_valid_(sample_valid_),
        .count_type   (count_type),
        .count_dir    (count_dir),
        .count_in     (count_in),
        .bin_val      (bin_val),
        .bin_valid    (bin_valid),
        .locked       (locked),
        .code_err     (code_err),
        .step_err     (step_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mod_of(input int t);
        case (t)
            0, 1:    return 1 << W;
            2:       return W;
            default: return 2 * W;
        endcase
    endfunction

    // Code for position idx, generated from each code's definition.
    function automatic logic [W-1:0] enc(input int t, input int idx);
        logic [W-1:0] c;
        case (t)
            0: c = W'(idx);
            1: c = W'(idx ^ (idx >> 1));
            2: c = W'(1 << (W - 1 - idx));
            default: begin
                c = '0;
                for (int k = 0; k < idx; k++) c = {~c[0], c[W-1:1]};
            end
        endcase
        return c;
    endfunction

    // Decode by searching the code table of the type.
    function automatic void mdec(input int t, input logic [W-1:0] c,
                                 output bit lg, output int idx);
        lg  = 1'b0;
        idx = 0;
        for (int k = 0; k < mod_of(t); k++) begin
            if (enc(t, k) == c) begin
                lg  = 1'b1;
                idx = k;
            end
        end
    endfunction

    typedef struct {
        bit have_ref;
        bit lk;
        int gc;
        int rref;
        int rtype;
        int bin;
        bit bv;
        bit ce;
        bit se;
        int ec;
    } mst_t;

    function automatic mst_t mzero();
        mst_t z;
        z.have_ref = 0; z.lk = 0; z.gc = 0; z.rref = 0; z.rtype = 0;
        z.bin = 0; z.bv = 0; z.ce = 0; z.se = 0; z.ec = 0;
        return z;
    endfunction

    function automatic mst_t mnext(mst_t s, logic sy, logic sv,
                                   logic [1:0] t, logic dir, logic [W-1:0] c);
        mst_t n = s;
        bit lg;
        int idx;
        int m;
        int d;
        bit hold;
        bit good;
        n.bv = 0; n.ce = 0; n.se = 0;
        if (!sy) begin
            n.have_ref = 0; n.lk = 0; n.gc = 0; n.ec = 0;
        end else if (!sv) begin
            mdec(int'(t), c, lg, idx);
            if (!lg) begin
                n.ce = 1; n.have_ref = 0; n.lk = 0; n.gc = 0;
                n.ec = (s.ec < 255) ? s.ec + 1 : 255;
            end else begin
                n.bv = 1;
                n.bin = idx;
                if (!s.have_ref || int'(t) != s.rtype) begin
                    n.lk = 0; n.gc = 0;
                end else begin
                    m    = mod_of(int'(t));
                    d    = (idx - s.rref + m) % m;
                    hold = (d == 0);
                    good = hold || (d == 1 && dir) || (d == m - 1 && !dir);
                    if (s.lk) begin
                        if (!good || (STRICT && hold)) begin
                            n.se = 1; n.lk = 0; n.gc = 0;
                            n.ec = (s.ec < 255) ? s.ec + 1 : 255;
                        end
                    end else if (hold) begin
                        if (STRICT) n.gc = 0;
                    end else if (good) begin
                        n.gc = s.gc + 1;
                        if (n.gc >= THR) n.lk = 1;
                    end else begin
                        n.gc = 0;
                    end
                end
                n.have_ref = 1;
                n.rref     = idx;
                n.rtype    = int'(t);
            end
        end
        return n;
    endfunction

    mst_t m = mzero();

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) m <= mzero();
        else m <= mnext(m, sync_, sample_valid_, count_type, count_dir, count_in);
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bin_val",   int'(bin_val),   m.bin);
            chk("bin_valid", int'(bin_valid), int'(m.bv));
            chk("locked",    int'(locked),    int'(m.lk));
            chk("code_err",  int'(code_err),  int'(m.ce));
            chk("step_err",  int'(step_err),  int'(m.se));
            chk("err_cnt",   int'(err_cnt),   m.ec);
        end
    end

    task automatic smp(input logic [1:0] t, input logic d, input logic [W-1:0] c);
        sample_valid_ = 1'b0;
        count_type    = t;
        count_dir     = d;
        count_in      = c;
        @(posedge clk);
        #1;
        sample_valid_ = 1'b1;
    endtask

    task automatic do_sync();
        sync_         = 1'b0;
        sample_valid_ = 1'b1;
        @(posedge clk);
        #1;
        sync_ = 1'b1;
    endtask

    int g_type;
    int g_idx;
    bit g_dir;
    int r;
    bit mlg;
    int midx;

    initial begin
        reset_        = 1'b0;
        sync_         = 1'b1;
        sample_valid_ = 1'b1;
        count_type    = 2'd0;
        count_dir     = 1'b1;
        count_in      = '0;

        // Pin the model's decoder to hand-derived values.
        mdec(1, 4'b1001, mlg, midx);
        chk("mdl_gray_1001", midx, 14);
        mdec(3, 4'b0001, mlg, midx);
        chk("mdl_john_0001", midx, 7);
        mdec(3, 4'b0100, mlg, midx);
        chk("mdl_john_0100_legal", int'(mlg), 0);
        mdec(2, 4'b0110, mlg, midx);
        chk("mdl_ring_0110_legal", int'(mlg), 0);
        mdec(2, 4'b0100, mlg, midx);
        chk("mdl_ring_0100", midx, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin_val", int'(bin_val), 0);
        chk("rst_bin_valid", int'(bin_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_code_err", int'(code_err), 0);
        chk("rst_step_err", int'(step_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        reset_ = 1'b1;
        chk_en = 1'b1;

        // 1: async reset mid-run, then re-acquire.
        smp(0, 1, 4'd3);
        smp(0, 1, 4'd4);
        smp(0, 1, 4'd5);
        chk("t1_locked_pre", int'(locked), 1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("t1_async_locked", int'(locked), 0);
        chk("t1_async_bin_val", int'(bin_val), 0);
        chk("t1_async_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        smp(0, 1, 4'd5);
        chk("t1_first_bv", int'(bin_valid), 1);
        chk("t1_first_locked", int'(locked), 0);
        smp(0, 1, 4'd6);
        chk("t1_second_locked", int'(locked), 0);

        // 2: binary up with wrap.
        do_sync();
        for (int i = 0; i <= 16; i++) begin
            smp(0, 1, W'(i % 16));
            chk("t2_bin_valid", int'(bin_valid), 1);
            chk("t2_bin_val", int'(bin_val), i % 16);
            if (i == 1) chk("t2_locked_s2", int'(locked), 0);
            if (i == 2) chk("t2_locked_s3", int'(locked), 1);
        end
        chk("t2_wrap_step_err", int'(step_err), 0);
        chk("t2_wrap_locked", int'(locked), 1);

        // Type change while locked: resync, no step error.
        smp(1, 1, 4'b0001);
        chk("tc_step_err", int'(step_err), 0);
        chk("tc_locked", int'(locked), 0);
        chk("tc_bin_val", int'(bin_val), 1);

        // 3: gray down.
        do_sync();
        smp(1, 0, 4'b0000);
        chk("t3_bin_val0", int'(bin_val), 0);
        smp(1, 0, 4'b1000);
        chk("t3_bin_val1", int'(bin_val), 15);
        smp(1, 0, 4'b1001);
        chk("t3_bin_val2", int'(bin_val), 14);
        chk("t3_locked", int'(locked), 1);
        chk("t3_err_cnt", int'(err_cnt), 0);

        // 4: ring illegal code while locked.
        do_sync();
        smp(2, 1, 4'b1000);
        smp(2, 1, 4'b0100);
        smp(2, 1, 4'b0010);
        chk("t4_locked", int'(locked), 1);
        smp(2, 1, 4'b0110);
        chk("t4_code_err", int'(code_err), 1);
        chk("t4_locked_after", int'(locked), 0);
        chk("t4_err_cnt", int'(err_cnt), 1);
        chk("t4_bin_val_hold", int'(bin_val), 2);
        chk("t4_no_bv", int'(bin_valid), 0);

        // 5: johnson up, then a jump.
        do_sync();
        smp(3, 1, 4'b0000);
        smp(3, 1, 4'b1000);
        smp(3, 1, 4'b1100);
        smp(3, 1, 4'b1110);
        chk("t5_bin_val", int'(bin_val), 3);
        chk("t5_locked", int'(locked), 1);
        smp(3, 1, 4'b0001);
        chk("t5_step_err", int'(step_err), 1);
        chk("t5_locked_after", int'(locked), 0);
        chk("t5_err_cnt", int'(err_cnt), 1);
        chk("t5_bin_val_jump", int'(bin_val), 7);

        // 6: sync with a simultaneous sample.
        do_sync();
        smp(0, 1, 4'd3);
        smp(0, 1, 4'd4);
        smp(0, 1, 4'd5);
        smp(0, 1, 4'd9);
        chk("t6_step_err", int'(step_err), 1);
        smp(0, 1, 4'd10);
        smp(0, 1, 4'd11);
        chk("t6_relocked", int'(locked), 1);
        chk("t6_err_cnt_pre", int'(err_cnt), 1);
        sync_ = 1'b0;
        smp(0, 1, 4'd12);
        sync_ = 1'b1;
        chk("t6_sync_locked", int'(locked), 0);
        chk("t6_sync_err_cnt", int'(err_cnt), 0);
        chk("t6_sync_bv", int'(bin_valid), 0);
        chk("t6_sync_bin_val", int'(bin_val), 11);

        // Hold while locked: error only in the strict build.
        smp(3, 1, 4'b1111);
        smp(3, 1, 4'b0111);
        smp(3, 1, 4'b0011);
        chk("t6_john_locked", int'(locked), 1);
        smp(3, 1, 4'b0011);
        chk("t6_hold_step_err", int'(step_err), int'(STRICT));
        chk("t6_hold_locked", int'(locked), int'(!STRICT));

        // err_cnt saturation.
        do_sync();
        repeat (260) smp(2, 1, 4'b0000);
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_code_err", int'(code_err), 1);
        do_sync();

        // Randomized run; the negedge compare checks every cycle.
        g_type = 0;
        g_idx  = 0;
        g_dir  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            r             = $urandom_range(0, 99);
            sync_         = 1'b1;
            sample_valid_ = 1'b0;
            if (r < 4) begin
                sync_         = 1'b0;
                sample_valid_ = 1'($urandom_range(0, 1));
                count_in      = enc(g_type, g_idx);
            end else if (r < 14) begin
                sample_valid_ = 1'b1;
                count_in      = W'($urandom);
            end else if (r < 20) begin
                count_in = W'($urandom);
            end else if (r < 25) begin
                g_type   = $urandom_range(0, 3);
                g_idx    = $urandom_range(0, mod_of(g_type) - 1);
                count_in = enc(g_type, g_idx);
            end else if (r < 33) begin
                count_in = enc(g_type, g_idx);
            end else if (r < 37) begin
                g_idx = g_dir ? (g_idx + mod_of(g_type) - 1) % mod_of(g_type)
                              : (g_idx + 1) % mod_of(g_type);
                count_in = enc(g_type, g_idx);
            end else begin
                if (r < 40) g_dir = !g_dir;
                g_idx = g_dir ? (g_idx + 1) % mod_of(g_type)
                              : (g_idx + mod_of(g_type) - 1) % mod_of(g_type);
                count_in = enc(g_type, g_idx);
            end
            count_type = 2'(g_type);
            count_dir  = g_dir;
            @(posedge clk);
            #1;
        end
        sync_         = 1'b1;
        sample_valid_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
